noc_mmr_tx: RTL and testbench

NOC_MMR_TX -- requirements
Module: noc_mmr_tx

---
 rtl/noc_mmr_pkg.sv | 18 +
 rtl/noc_mmr_tx_if.sv | 39 +++
 rtl/noc_mmr_tx.sv | 132 +++++++++++++
 tb/tb_noc_mmr_tx.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_mmr_pkg.sv
// Shared definitions for the NoC MMR transmit block:
// register offsets, STATUS bit positions and FSM encoding.
package noc_mmr_pkg;

  localparam logic [31:0] OFF_DATA    = 32'h0000_0000;
  localparam logic [31:0] OFF_TRIGGER = 32'h0000_0010;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0014;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/noc_mmr_tx_if.sv
// Memory-stage MMR access plus NoC flit handshake bundle.
// master drives accesses and flit_ready; slave is the transmitter.
interface noc_mmr_tx_if;

  logic        mmr_we;
  logic [31:0] mmr_location;
  logic [31:0] mmr_wdata;
  logic [31:0] mmr_rdata;
  logic [31:0] flit_data;
  logic        flit_valid;
  logic        flit_last;
  logic        flit_ready;
  logic        busy;

  modport master (
    output mmr_we,
    output mmr_location,
    output mmr_wdata,
    output flit_ready,
    input  mmr_rdata,
    input  flit_data,
    input  flit_valid,
    input  flit_last,
    input  busy
  );

  modport slave (
    input  mmr_we,
    input  mmr_location,
    input  mmr_wdata,
    input  flit_ready,
    output mmr_rdata,
    output flit_data,
    output flit_valid,
    output flit_last,
    output busy
  );

endinterface

// File: rtl/noc_mmr_tx.sv
// MMR-programmed packet transmitter: four DATA words are snapshotted
// on TRIGGER and streamed out as NoC flits with valid/ready.
module noc_mmr_tx
  import noc_mmr_pkg::*;
#(
  parameter logic [31:0] MMR_BASE  = 32'h0000_4000,
  parameter int          NUM_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mmr_we,
  input  logic [31:0] mmr_location,
  input  logic [31:0] mmr_wdata,
  output logic [31:0] mmr_rdata,
  output logic [31:0] flit_data,
  output logic        flit_valid,
  output logic        flit_last,
  input  logic        flit_ready,
  output logic        busy
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  state_e state_q;
  state_e state_d;

  logic [31:0]   data_q   [NUM_WORDS];
  logic [31:0]   shadow_q [NUM_WORDS];
  logic [IW-1:0] idx_q;
  logic          done_q;
  logic          overrun_q;

  logic [29:0]   woff;
  logic [IW-1:0] widx;
  logic          hit_data;
  logic          hit_trig;
  logic          hit_stat;
  logic          trig_wr;
  logic          stat_wr;
  logic          hs;
  logic          last_hs;
  logic          start;
  logic [31:0]   status;
  logic          unused_addr_lsb;

  // Byte lanes are not decoded; the window is word-granular.
  assign unused_addr_lsb = &{1'b0, mmr_location[1:0]};

  assign woff     = mmr_location[31:2] - MMR_BASE[31:2];
  assign widx     = woff[IW-1:0];
  assign hit_data = (woff < 30'(NUM_WORDS)) && (woff >= OFF_DATA[31:2]);
  assign hit_trig = (woff == OFF_TRIGGER[31:2]);
  assign hit_stat = (woff == OFF_STATUS[31:2]);
  assign trig_wr  = mmr_we && hit_trig;
  assign stat_wr  = mmr_we && hit_stat;

  assign busy       = (state_q == S_SEND);
  assign flit_valid = busy;
  assign flit_last  = busy && (idx_q == LAST_IDX);
  assign flit_data  = busy ? shadow_q[idx_q] : '0;
  assign hs         = flit_valid && flit_ready;
  assign last_hs    = hs && flit_last;

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = busy;
    status[ST_DONE]     = done_q;
    status[ST_OVERRUN]  = overrun_q;
  end

  always_comb begin
    mmr_rdata = '0;
    unique case (1'b1)
      hit_data: mmr_rdata = data_q[widx];
      hit_stat: mmr_rdata = status;
      default:  mmr_rdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig_wr && mmr_wdata[0]) begin
          state_d = S_SEND;
          start   = 1'b1;
        end
      end
      S_SEND: begin
        if (last_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        data_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (mmr_we && hit_data) data_q[widx] <= mmr_wdata;

      // The packet in flight reads only the shadow copy.
      if (start) begin
        shadow_q <= data_q;
        idx_q    <= '0;
      end else if (hs) begin
        idx_q <= idx_q + 1'b1;
      end

      if (start)                       done_q <= 1'b0;
      else if (last_hs)                done_q <= 1'b1;
      else if (stat_wr && mmr_wdata[1]) done_q <= 1'b0;

      if (trig_wr && busy)              overrun_q <= 1'b1;
      else if (stat_wr && mmr_wdata[2]) overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_mmr_tx.sv
// Directed and randomized bench for noc_mmr_tx against a
// register/queue model of the MMR window and packet stream.
module tb_noc_mmr_tx;

  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam logic [31:0] A_TRIG = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  noc_mmr_tx_if bus ();

  noc_mmr_tx #(.MMR_BASE(BASE), .NUM_WORDS(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mmr_we       (bus.mmr_we),
    .mmr_location (bus.mmr_location),
    .mmr_wdata    (bus.mmr_wdata),
    .mmr_rdata    (bus.mmr_rdata),
    .flit_data    (bus.flit_data),
    .flit_valid   (bus.flit_valid),
    .flit_last    (bus.flit_last),
    .flit_ready   (bus.flit_ready),
    .busy         (bus.busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_data [4];
  bit          m_done;
  bit          m_ovr;

  function automatic logic [31:0] exp_status(input bit b);
    return {29'b0, m_ovr, m_done, b};
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    @(negedge clk);
    bus.mmr_we = 1'b1;
    bus.mmr_location = a;
    bus.mmr_wdata = d;
    @(posedge clk);
    #1 bus.mmr_we = 1'b0;
    off = a - BASE;
    if (off < 32'h10) m_data[off[3:2]] = d;
    if (off[31:2] == 30'h5) begin
      if (d[1]) m_done = 1'b0;
      if (d[2]) m_ovr = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.mmr_location = a;
    #1 d = bus.mmr_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    #3;
    bus.mmr_location = A_STAT;
    #1;
    n_vec++;
    if ({bus.flit_valid, bus.flit_last, bus.busy, bus.flit_data} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%h, want all 0",
               bus.flit_valid, bus.flit_last, bus.busy, bus.flit_data);
    end
    n_vec++;
    if (bus.mmr_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_status: got %h want 0", bus.mmr_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(BASE, d);
    n_vec++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL reset_data0: got %h want 0", d);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    bus.flit_ready = 1'b1;
    wr(BASE + 0, 32'h11);
    wr(BASE + 4, 32'h22);
    wr(BASE + 8, 32'h33);
    wr(BASE + 12, 32'h44);
    wr(A_TRIG, 32'h1);
    m_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus.flit_valid, bus.flit_last, bus.flit_data} !==
          {1'b1, (i == 3), m_data[i]}) begin
        n_err++;
        $display("FAIL basic_flit%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 i, bus.flit_valid, bus.flit_last, bus.flit_data, (i == 3), m_data[i]);
      end
      @(posedge clk);
      #1;
    end
    m_done = 1'b1;
    n_vec++;
    if (bus.flit_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: got v=%b b=%b want 0 0", bus.flit_valid, bus.busy);
    end
    rd(A_STAT, d);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++;
      $display("FAIL basic_status: got %h want %h", d, 32'h2);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    bus.flit_ready = 1'b1;
    wr(A_TRIG, 32'h1);
    m_done = 1'b0;
    @(posedge clk);
    #1 bus.flit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if ({bus.flit_valid, bus.flit_last, bus.flit_data} !== {1'b1, 1'b0, 32'h22}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b l=%b d=%h want v=1 l=0 d=22",
                 k, bus.flit_valid, bus.flit_last, bus.flit_data);
      end
    end
    bus.flit_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_vec++;
      if ({bus.flit_valid, bus.flit_last, bus.flit_data} !==
          {1'b1, (i == 3), m_data[i]}) begin
        n_err++;
        $display("FAIL stall_flit%0d: got v=%b l=%b d=%h want l=%b d=%h",
                 i, bus.flit_valid, bus.flit_last, bus.flit_data, (i == 3), m_data[i]);
      end
      @(posedge clk);
      #1;
    end
    m_done = 1'b1;
    rd(A_STAT, d);
    n_vec++;
    if (d !== exp_status(1'b0)) begin
      n_err++;
      $display("FAIL stall_status: got %h want %h", d, exp_status(1'b0));
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    bus.flit_ready = 1'b0;
    wr(A_TRIG, 32'h1);
    m_done = 1'b0;
    wr(A_TRIG, 32'h1);
    m_ovr = 1'b1;
    rd(A_STAT, d);
    n_vec++;
    if (d !== 32'h5) begin
      n_err++;
      $display("FAIL ovr_status_busy: got %h want 5", d);
    end
    bus.flit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus.flit_valid, bus.flit_last, bus.flit_data} !==
          {1'b1, (i == 3), m_data[i]}) begin
        n_err++;
        $display("FAIL ovr_flit%0d: got v=%b l=%b d=%h want l=%b d=%h",
                 i, bus.flit_valid, bus.flit_last, bus.flit_data, (i == 3), m_data[i]);
      end
      @(posedge clk);
      #1;
    end
    m_done = 1'b1;
    rd(A_STAT, d);
    n_vec++;
    if (d !== 32'h6) begin
      n_err++;
      $display("FAIL ovr_status_after: got %h want 6", d);
    end
    wr(A_STAT, 32'h4);
    rd(A_STAT, d);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++;
      $display("FAIL ovr_clear: got %h want 2", d);
    end
    wr(A_STAT, 32'h2);
    rd(A_STAT, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL done_clear: got %h want 0", d);
    end
  endtask

  task automatic test_shadow();
    logic [31:0] d;
    logic [31:0] snap [4];
    bus.flit_ready = 1'b0;
    snap = m_data;
    wr(A_TRIG, 32'h1);
    wr(BASE, 32'hAA);
    bus.flit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus.flit_valid, bus.flit_data} !== {1'b1, snap[i]}) begin
        n_err++;
        $display("FAIL shadow_flit%0d: got v=%b d=%h want v=1 d=%h",
                 i, bus.flit_valid, bus.flit_data, snap[i]);
      end
      @(posedge clk);
      #1;
    end
    rd(BASE, d);
    n_vec++;
    if (d !== 32'hAA) begin
      n_err++;
      $display("FAIL shadow_rd_data0: got %h want aa", d);
    end
    wr(A_TRIG, 32'h1);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus.flit_valid, bus.flit_data} !== {1'b1, m_data[i]}) begin
        n_err++;
        $display("FAIL shadow_next%0d: got v=%b d=%h want v=1 d=%h",
                 i, bus.flit_valid, bus.flit_data, m_data[i]);
      end
      @(posedge clk);
      #1;
    end
    m_done = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus.flit_ready = 1'b1;
    wr(A_TRIG, 32'h1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.flit_valid, bus.flit_last, bus.busy, bus.flit_data} !== 35'd0) begin
      n_err++;
      $display("FAIL midrst_async: got v=%b l=%b b=%b d=%h want all 0",
               bus.flit_valid, bus.flit_last, bus.busy, bus.flit_data);
    end
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    m_done = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mmr_we = 1'b1;
    bus.mmr_location = BASE + 4;
    bus.mmr_wdata = 32'h5A;
    @(posedge clk);
    #1 bus.mmr_we = 1'b0;
    m_data[1] = 32'h5A;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (bus.flit_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_noflit%0d: got v=%b want 0", k, bus.flit_valid);
      end
      @(posedge clk);
      #1;
    end
    rd(A_STAT, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_status: got %h want 0", d);
    end
    rd(BASE, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_data0: got %h want 0", d);
    end
    rd(BASE + 4, d);
    n_vec++;
    if (d !== 32'h5A) begin
      n_err++;
      $display("FAIL midrst_first_write: got %h want 5a", d);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus.flit_ready = 1'b1;
    wr(BASE + 32'h20, 32'hDEAD_BEEF);
    wr(A_TRIG, 32'h0);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (bus.flit_valid !== 1'b0) begin
        n_err++;
        $display("FAIL unmap_noflit%0d: got v=%b want 0", k, bus.flit_valid);
      end
      @(posedge clk);
      #1;
    end
    rd(A_STAT, d);
    n_vec++;
    if (d !== exp_status(1'b0)) begin
      n_err++;
      $display("FAIL unmap_status: got %h want %h", d, exp_status(1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 32'(4 * i), d);
      n_vec++;
      if (d !== m_data[i]) begin
        n_err++;
        $display("FAIL unmap_data%0d: got %h want %h", i, d, m_data[i]);
      end
    end
    rd(BASE + 32'h20, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL unmap_read: got %h want 0", d);
    end
    rd(A_TRIG, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL trig_read: got %h want 0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] q [$];
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 4; i++) wr(BASE + 32'(4 * i), $urandom);
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(m_data[i]);
      bus.flit_ready = 1'($urandom_range(0, 1));
      wr(A_TRIG, 32'h1 | ($urandom & 32'hFFFF_FFFE));
      m_done = 1'b0;
      for (int cyc = 0; cyc < 200 && q.size() > 0; cyc++) begin
        bit r;
        bit w;
        logic [1:0] wi;
        logic [31:0] wd;
        n_vec++;
        if ({bus.flit_valid, bus.flit_last, bus.flit_data} !==
            {1'b1, (q.size() == 1), q[0]}) begin
          n_err++;
          $display("FAIL rand_p%0d_c%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   p, cyc, bus.flit_valid, bus.flit_last, bus.flit_data,
                   (q.size() == 1), q[0]);
        end
        r = 1'($urandom_range(0, 1));
        w = ($urandom_range(0, 3) == 0);
        wi = 2'($urandom_range(0, 3));
        wd = $urandom;
        bus.flit_ready = r;
        bus.mmr_we = w;
        bus.mmr_location = BASE + {28'd0, wi, 2'b00};
        bus.mmr_wdata = wd;
        @(posedge clk);
        #1 bus.mmr_we = 1'b0;
        if (w) m_data[wi] = wd;
        if (r) void'(q.pop_front());
      end
      n_vec++;
      if (q.size() != 0 || bus.flit_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rand_p%0d_end: left=%0d v=%b want left=0 v=0",
                 p, q.size(), bus.flit_valid);
      end
      m_done = 1'b1;
      rd(A_STAT, d);
      n_vec++;
      if (d !== exp_status(1'b0)) begin
        n_err++;
        $display("FAIL rand_p%0d_status: got %h want %h", p, d, exp_status(1'b0));
      end
      for (int i = 0; i < 4; i++) begin
        rd(BASE + 32'(4 * i), d);
        n_vec++;
        if (d !== m_data[i]) begin
          n_err++;
          $display("FAIL rand_p%0d_data%0d: got %h want %h", p, i, d, m_data[i]);
        end
      end
    end
  endtask

  initial begin
    bus.mmr_we = 1'b0;
    bus.mmr_location = '0;
    bus.mmr_wdata = '0;
    bus.flit_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    m_done = 1'b0;
    m_ovr = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_shadow();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
